// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Byte-wise block copy engine that masters a single-port data RAM. After a
// Start command it alternates one read cycle and one write cycle per byte,
// walking source and destination upward in address order. Both pointers wrap
// modulo 2^ADDR_W.
//
// Ports
//   CLK         system clock, rising edge
//   Reset       asynchronous, active-high reset
//   Start       command strobe, accepted only while idle
//   SrcAddr     first source byte address
//   DstAddr     first destination byte address
//   Len         byte count (0 completes at once; values above 2^ADDR_W saturate)
//   Busy        copy in progress (RD/WR states)
//   Done        one-cycle completion pulse
//   BytesLeft   bytes still to be written (0 when not busy)
//   MemRead     RAM read enable
//   MemWrite    RAM write enable
//   DataSrcA    read address during a read, write data during a write
//   DataSrcB    write address during a write
//   DataMemOut  combinational RAM read data
//
// DATA_W must equal ADDR_W: DataSrcA carries both a read address and a data
// byte, depending on the cycle.
// -----------------------------------------------------------------------------
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] SrcAddr,
    input  logic [ADDR_W-1:0] DstAddr,
    input  logic [LEN_W-1:0]  Len,
    output logic              Busy,
    output logic              Done,
    output logic [LEN_W-1:0]  BytesLeft,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] DataSrcA,
    output logic [ADDR_W-1:0] DataSrcB,
    input  logic [DATA_W-1:0] DataMemOut
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_buf;
    logic [LEN_W-1:0]  r_count;

    logic              w_accept;
    logic              w_len_zero;
    logic [LEN_W-1:0]  w_len_sat;

    assign w_accept   = (r_state == S_IDLE) && Start;
    assign w_len_zero = (Len == '0);
    // A copy can never usefully exceed the whole address space.
    assign w_len_sat  = (Len > MAX_LEN) ? MAX_LEN : Len;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next = w_len_zero ? S_DONE : S_RD;
                end
            end
            S_RD:   w_next = S_WR;
            // Last byte is the one written while count is still 1.
            S_WR:   w_next = (r_count == LEN_W'(1)) ? S_DONE : S_RD;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode (state and pointer registers only)
    // ------------------------------------------------------------------
    always_comb begin
        Busy      = 1'b0;
        Done      = 1'b0;
        BytesLeft = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        DataSrcA  = '0;
        DataSrcB  = '0;
        unique case (r_state)
            S_RD: begin
                Busy      = 1'b1;
                BytesLeft = r_count;
                MemRead   = 1'b1;
                DataSrcA  = r_src;
            end
            S_WR: begin
                Busy      = 1'b1;
                BytesLeft = r_count;
                MemWrite  = 1'b1;
                DataSrcA  = r_buf;
                DataSrcB  = r_dst;
            end
            S_DONE: begin
                Done = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pointers, byte counter and the single-byte holding buffer
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_buf   <= '0;
            r_count <= '0;
        end else begin
            if (w_accept && !w_len_zero) begin
                r_src   <= SrcAddr;
                r_dst   <= DstAddr;
                r_count <= w_len_sat;
            end
            if (r_state == S_RD) begin
                r_buf <= DataMemOut;
            end
            if (r_state == S_WR) begin
                // Natural ADDR_W-bit overflow gives the wrap from top to 0.
                r_src   <= r_src + ADDR_W'(1);
                r_dst   <= r_dst + ADDR_W'(1);
                r_count <= r_count - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] SrcAddr, DstAddr;
    logic [8:0] Len;
    logic       Busy, Done, MemRead, MemWrite;
    logic [8:0] BytesLeft;
    logic [7:0] DataSrcA, DataSrcB, DataMemOut;

    always #5 CLK = ~CLK;

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8), .LEN_W(9)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start),
        .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len),
        .Busy(Busy), .Done(Done), .BytesLeft(BytesLeft),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .DataSrcA(DataSrcA), .DataSrcB(DataSrcB), .DataMemOut(DataMemOut)
    );

    // RAM model: combinational read, write on rising edge. Preload goes
    // through the same process so the array has a single writer.
    logic [7:0] mem [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = '0, pl_data = '0;
    assign DataMemOut = mem[DataSrcA];
    always @(posedge CLK) begin
        if (MemWrite)   mem[DataSrcB] <= DataSrcA;
        else if (pl_en) mem[pl_addr]  <= pl_data;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, ".busy"}, Busy, 0);
        chk({nm, ".done"}, Done, 0);
        chk({nm, ".left"}, BytesLeft, 0);
        chk({nm, ".rd"},   MemRead, 0);
        chk({nm, ".wr"},   MemWrite, 0);
        chk({nm, ".srca"}, DataSrcA, 0);
        chk({nm, ".srcb"}, DataSrcB, 0);
    endtask

    // Issue a copy and watch it cycle by cycle. Cycle 0 is the cycle Start
    // is high. inj>0 pulses Start with other operands during that cycle.
    task automatic run_copy(input string nm, input logic [7:0] s, input logic [7:0] d,
                            input logic [8:0] l, input int inj, input int exp_done,
                            input int exp_busy, input logic [8:0] left0);
        int cyc = 1, done_at = -1, ndone = 0, nbusy = 0, nrd = 0, nwr = 0, both = 0;
        logic [7:0] ea;
        SrcAddr = s; DstAddr = d; Len = l; Start = 1'b1;
        tick();
        // Scramble operands: they must only matter on the accepting edge.
        Start = 1'b0; SrcAddr = ~s; DstAddr = ~d; Len = 9'd7;
        while (cyc <= exp_done + 4) begin
            if (cyc == inj) begin
                Start = 1'b1; SrcAddr = 8'h00; DstAddr = 8'h00; Len = 9'd2;
            end else begin
                Start = 1'b0;
            end
            if (MemRead && MemWrite) both++;
            if (MemRead) begin
                ea = s + nrd[7:0];
                chk({nm, ".rdaddr"}, DataSrcA, ea);
                chk({nm, ".left"}, BytesLeft, left0 - nrd[8:0]);
                nrd++;
            end
            if (MemWrite) begin
                ea = d + nwr[7:0];
                chk({nm, ".wraddr"}, DataSrcB, ea);
                nwr++;
            end
            if (Busy) nbusy++;
            if (Done) begin
                ndone++;
                if (done_at < 0) done_at = cyc;
            end
            tick();
            cyc++;
        end
        chk({nm, ".done_cyc"}, done_at, exp_done);
        chk({nm, ".ndone"}, ndone, 1);
        chk({nm, ".busy_cyc"}, nbusy, exp_busy);
        chk({nm, ".nrd"}, nrd, exp_busy / 2);
        chk({nm, ".nwr"}, nwr, exp_busy / 2);
        chk({nm, ".overlap"}, both, 0);
    endtask

    typedef struct {
        string          nm;
        logic [7:0]     src, dst;
        logic [8:0]     len;
        logic [0:3][7:0] pre;   // preloaded at src..src+3
        logic [0:3][7:0] exp;   // expected at dst..dst+nchk-1
        int             nchk;
        int             inj;
        int             done_c, busy_c;
        logic [8:0]     left0;
    } vec_t;

    function automatic vec_t mk(string nm, logic [7:0] s, logic [7:0] d, logic [8:0] l,
                                logic [31:0] pre, logic [31:0] exp, int nchk, int inj,
                                int dc, int bc, logic [8:0] left0);
        vec_t v;
        v.nm = nm; v.src = s; v.dst = d; v.len = l; v.pre = pre; v.exp = exp;
        v.nchk = nchk; v.inj = inj; v.done_c = dc; v.busy_c = bc; v.left0 = left0;
        return v;
    endfunction

    vec_t vt [7];

    initial begin
        vt[0] = mk("basic",   8'h10, 8'h80, 9'd4,   32'hA1B2C3D4, 32'hA1B2C3D4, 4, -1, 9,   8,   9'd4);
        vt[1] = mk("len0",    8'h30, 8'h50, 9'd0,   32'h01020304, 32'h0,        0, -1, 1,   0,   9'd0);
        vt[2] = mk("wrap",    8'hFE, 8'h40, 9'd4,   32'h11223344, 32'h11223344, 4, -1, 9,   8,   9'd4);
        vt[3] = mk("overlap", 8'h20, 8'h21, 9'd3,   32'h5A007788, 32'h5A5A5A00, 3, -1, 7,   6,   9'd3);
        vt[4] = mk("len1",    8'h05, 8'h06, 9'd1,   32'h9C010203, 32'h9C000000, 1, -1, 3,   2,   9'd1);
        vt[5] = mk("busy_st", 8'h10, 8'h90, 9'd4,   32'hE1E2E3E4, 32'hE1E2E3E4, 4, 3,  9,   8,   9'd4);
        vt[6] = mk("sat",     8'h00, 8'h00, 9'd300, 32'h0,        32'h0,        0, -1, 513, 512, 9'd256);

        Reset = 1'b1; Start = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
        #2;
        chk_quiet("reset");
        tick(); tick();
        Reset = 1'b0;
        tick();
        chk_quiet("idle");

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 4; k++) poke(vt[i].src + 8'(k), vt[i].pre[k]);
            run_copy(vt[i].nm, vt[i].src, vt[i].dst, vt[i].len, vt[i].inj,
                     vt[i].done_c, vt[i].busy_c, vt[i].left0);
            for (int k = 0; k < vt[i].nchk; k++)
                chk({vt[i].nm, ".data"}, mem[vt[i].dst + 8'(k)], vt[i].exp[k]);
        end
        // The ignored Start in busy_st must not have touched address 0.
        chk("busy_st.noclobber", mem[8'h00], 8'h00);

        // Reset during the third write of an 8-byte copy.
        for (int k = 0; k < 8; k++) poke(8'h60 + 8'(k), 8'(k + 1));
        for (int k = 0; k < 8; k++) poke(8'hA0 + 8'(k), 8'hEE);
        SrcAddr = 8'h60; DstAddr = 8'hA0; Len = 9'd8; Start = 1'b1;
        tick();                       // cycle 1: RD1
        Start = 1'b0;
        for (int c = 2; c <= 6; c++) tick();
        chk("rst.in_wr3", MemWrite, 1);
        chk("rst.left_wr3", BytesLeft, 9'd6);
        Reset = 1'b1;
        #1;
        chk_quiet("rst.now");
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst.held_done", Done, 0);
        end
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_quiet("rst.after");
        end
        chk("rst.b0", mem[8'hA0], 8'h01);
        chk("rst.b1", mem[8'hA1], 8'h02);
        for (int k = 2; k < 8; k++) chk("rst.untouched", mem[8'hA0 + 8'(k)], 8'hEE);

        poke(8'h70, 8'h3C);
        run_copy("post_rst", 8'h70, 8'h71, 9'd1, -1, 3, 2, 9'd1);
        chk("post_rst.data", mem[8'h71], 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
